// File: rtl/atom_mem_arbiter.sv
// rtl/atom_mem_arbiter.sv - N-channel valid/ack memory port arbiter with optional watchdog
module atom_mem_arbiter #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH*ADDR_W-1:0]   req_addr_i,
  input  logic [N_CH*DATA_W-1:0]   req_data_i,
  input  logic [N_CH*DATA_W/8-1:0] req_sel_i,
  input  logic [N_CH-1:0]          req_we_i,
  input  logic [N_CH-1:0]          req_valid_i,
  output logic [N_CH-1:0]          req_ack_o,
  output logic [N_CH-1:0]          req_err_o,
  output logic [DATA_W-1:0]        req_data_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_data_o,
  output logic [DATA_W/8-1:0]      mem_sel_o,
  output logic                     mem_we_o,
  output logic                     mem_valid_o,
  input  logic [DATA_W-1:0]        mem_data_i,
  input  logic                     mem_ack_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int GW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] PTR_RST  = GW'(N_CH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   win;
  logic            any_valid;
  logic            done;
  logic            timed_out;

  // Pick the winning channel among the current requests
  always_comb begin
    int   idx;
    logic found;
    win       = '0;
    idx       = 0;
    found     = 1'b0;
    any_valid = |req_valid_i;
    if (RR_MODE != 0) begin
      // Search starts just after the last served channel, wrapping around
      for (int k = 1; k <= N_CH; k++) begin
        idx = (int'(rr_ptr_q) + k) % N_CH;
        if (!found && req_valid_i[idx]) begin
          win   = GW'(idx);
          found = 1'b1;
        end
      end
    end else begin
      // Descending scan so the lowest set index is the last write
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (req_valid_i[i]) begin
          win = GW'(i);
        end
      end
    end
  end

  // FSM next state, downstream mux and completion outputs
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    done        = 1'b0;
    timed_out   = 1'b0;
    req_data_o  = '0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    mem_sel_o   = '0;
    mem_we_o    = 1'b0;
    mem_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_valid) begin
          grant_d = win;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_valid_o = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
          if (GW'(i) == grant_q) begin
            mem_addr_o = req_addr_i[i*ADDR_W +: ADDR_W];
            mem_data_o = req_data_i[i*DATA_W +: DATA_W];
            mem_sel_o  = req_sel_i[i*SEL_W +: SEL_W];
            mem_we_o   = req_we_i[i];
          end
        end
        // A real ack beats a watchdog expiry in the same cycle
        if (mem_ack_i) begin
          done       = 1'b1;
          req_data_o = mem_data_i;
          state_d    = IDLE;
          rr_ptr_d   = grant_q;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          done      = 1'b1;
          timed_out = 1'b1;
          state_d   = IDLE;
          rr_ptr_d  = grant_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A transaction aborted by reset never reports completion
    for (int i = 0; i < N_CH; i++) begin
      req_ack_o[i] = done && !rst_i && (GW'(i) == grant_q);
      req_err_o[i] = timed_out && !rst_i && (GW'(i) == grant_q);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PTR_RST;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_atom_mem_arbiter.sv
// tb/tb_atom_mem_arbiter.sv - directed self-checking bench for atom_mem_arbiter
module tb_atom_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_sel;
  logic [1:0]  req_we;
  logic [1:0]  req_valid;
  logic [31:0] mem_rdata;
  logic        ack_man;
  logic        auto_ack;

  logic [1:0]  rr_ack, rr_err, fp_ack, fp_err, to_ack, to_err;
  logic [31:0] rr_rdata, fp_rdata, to_rdata;
  logic [31:0] rr_addr, fp_addr, to_addr;
  logic [31:0] rr_wdata, fp_wdata, to_wdata;
  logic [3:0]  rr_sel, fp_sel, to_sel;
  logic        rr_we, fp_we, to_we;
  logic        rr_valid, fp_valid, to_valid;
  logic        rr_mack, fp_mack, to_mack;

  int checks = 0;
  int passes = 0;

  assign rr_mack = auto_ack ? rr_valid : ack_man;
  assign fp_mack = auto_ack ? fp_valid : ack_man;
  assign to_mack = ack_man;

  always #5 clk = ~clk;

  atom_mem_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(0)) u_rr (
    .clk_i(clk), .rst_i(rst), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_sel_i(req_sel), .req_we_i(req_we), .req_valid_i(req_valid),
    .req_ack_o(rr_ack), .req_err_o(rr_err), .req_data_o(rr_rdata),
    .mem_addr_o(rr_addr), .mem_data_o(rr_wdata), .mem_sel_o(rr_sel),
    .mem_we_o(rr_we), .mem_valid_o(rr_valid), .mem_data_i(mem_rdata), .mem_ack_i(rr_mack)
  );

  atom_mem_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT(0)) u_fp (
    .clk_i(clk), .rst_i(rst), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_sel_i(req_sel), .req_we_i(req_we), .req_valid_i(req_valid),
    .req_ack_o(fp_ack), .req_err_o(fp_err), .req_data_o(fp_rdata),
    .mem_addr_o(fp_addr), .mem_data_o(fp_wdata), .mem_sel_o(fp_sel),
    .mem_we_o(fp_we), .mem_valid_o(fp_valid), .mem_data_i(mem_rdata), .mem_ack_i(fp_mack)
  );

  atom_mem_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(8)) u_to (
    .clk_i(clk), .rst_i(rst), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_sel_i(req_sel), .req_we_i(req_we), .req_valid_i(req_valid),
    .req_ack_o(to_ack), .req_err_o(to_err), .req_data_o(to_rdata),
    .mem_addr_o(to_addr), .mem_data_o(to_wdata), .mem_sel_o(to_sel),
    .mem_we_o(to_we), .mem_valid_o(to_valid), .mem_data_i(mem_rdata), .mem_ack_i(to_mack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = 2'b00;
    ack_man   = 1'b0;
    auto_ack  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++; if (rr_valid !== 1'b0) $display("FAIL reset_mem_valid got=%b exp=0", rr_valid); else passes++;
    checks++; if (rr_ack !== 2'b00) $display("FAIL reset_ack got=%b exp=00", rr_ack); else passes++;
    checks++; if (rr_err !== 2'b00) $display("FAIL reset_err got=%b exp=00", rr_err); else passes++;
    checks++; if (rr_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=0", rr_addr); else passes++;
    checks++; if (rr_rdata !== 32'h0) $display("FAIL reset_req_data got=%h exp=0", rr_rdata); else passes++;
    checks++; if (to_valid !== 1'b0) $display("FAIL reset_to_valid got=%b exp=0", to_valid); else passes++;
  endtask

  task automatic test_single_read;
    do_reset();
    req_valid = 2'b10;
    tick();
    checks++; if (rr_valid !== 1'b1) $display("FAIL read_mem_valid got=%b exp=1", rr_valid); else passes++;
    checks++; if (rr_addr !== 32'h100) $display("FAIL read_mem_addr got=%h exp=100", rr_addr); else passes++;
    checks++; if (rr_we !== 1'b0) $display("FAIL read_mem_we got=%b exp=0", rr_we); else passes++;
    checks++; if (rr_sel !== 4'h3) $display("FAIL read_mem_sel got=%h exp=3", rr_sel); else passes++;
    checks++; if (rr_ack !== 2'b00) $display("FAIL read_early_ack got=%b exp=00", rr_ack); else passes++;
    tick();
    checks++; if (rr_ack !== 2'b00) $display("FAIL read_wait_ack got=%b exp=00", rr_ack); else passes++;
    tick();
    ack_man   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (rr_ack !== 2'b10) $display("FAIL read_ack got=%b exp=10", rr_ack); else passes++;
    checks++; if (rr_err !== 2'b00) $display("FAIL read_err got=%b exp=00", rr_err); else passes++;
    checks++; if (rr_rdata !== 32'hDEADBEEF) $display("FAIL read_data got=%h exp=deadbeef", rr_rdata); else passes++;
    tick();
    ack_man   = 1'b0;
    req_valid = 2'b00;
    #1;
    checks++; if (rr_valid !== 1'b0) $display("FAIL read_valid_drop got=%b exp=0", rr_valid); else passes++;
    checks++; if (rr_ack !== 2'b00) $display("FAIL read_ack_pulse got=%b exp=00", rr_ack); else passes++;
  endtask

  task automatic test_back_to_back;
    int   n;
    logic prev;
    logic [1:0] exp;
    do_reset();
    auto_ack  = 1'b1;
    mem_rdata = 32'h12345678;
    req_valid = 2'b11;
    n    = 0;
    prev = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      tick();
      if (rr_ack !== 2'b00) begin
        exp = (n % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (rr_ack !== exp) $display("FAIL rr_order n=%0d got=%b exp=%b", n, rr_ack, exp); else passes++;
        checks++; if (rr_rdata !== 32'h12345678) $display("FAIL rr_data got=%h exp=12345678", rr_rdata); else passes++;
        checks++; if (prev !== 1'b0) $display("FAIL rr_idle_gap got=%b exp=0", prev); else passes++;
        n++;
      end
      if (fp_ack !== 2'b00) begin
        checks++; if (fp_ack !== 2'b01) $display("FAIL fp_starve got=%b exp=01", fp_ack); else passes++;
      end
      prev = (rr_ack !== 2'b00);
    end
    checks++; if (n < 4) $display("FAIL rr_count got=%0d exp>=4", n); else passes++;
    req_valid = 2'b00;
    auto_ack  = 1'b0;
    tick();
  endtask

  task automatic test_fixed_priority;
    int   nfp;
    int   guard;
    logic got;
    do_reset();
    auto_ack  = 1'b1;
    req_valid = 2'b11;
    nfp   = 0;
    guard = 0;
    while (nfp < 4 && guard < 20) begin
      tick();
      guard++;
      if (fp_ack !== 2'b00) begin
        checks++; if (fp_ack !== 2'b01) $display("FAIL fp_prio got=%b exp=01", fp_ack); else passes++;
        nfp++;
      end
    end
    checks++; if (nfp != 4) $display("FAIL fp_count got=%0d exp=4", nfp); else passes++;
    tick();
    req_valid = 2'b10;
    got   = 1'b0;
    guard = 0;
    while (!got && guard < 6) begin
      tick();
      guard++;
      if (fp_ack !== 2'b00) got = 1'b1;
    end
    checks++; if (fp_ack !== 2'b10) $display("FAIL fp_ch1_served got=%b exp=10", fp_ack); else passes++;
    req_valid = 2'b00;
    auto_ack  = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    int pos;
    do_reset();
    mem_rdata = 32'hA5A5A5A5;
    req_valid = 2'b01;
    pos = 0;
    for (int i = 1; i <= 20 && pos == 0; i++) begin
      tick();
      if (i == 1) begin
        checks++; if (to_valid !== 1'b1) $display("FAIL to_valid_rise got=%b exp=1", to_valid); else passes++;
      end
      if (to_ack !== 2'b00) begin
        pos = i;
        checks++; if (to_ack !== 2'b01) $display("FAIL to_ack got=%b exp=01", to_ack); else passes++;
        checks++; if (to_err !== 2'b01) $display("FAIL to_err got=%b exp=01", to_err); else passes++;
        checks++; if (to_rdata !== 32'h0) $display("FAIL to_data got=%h exp=0", to_rdata); else passes++;
      end
    end
    checks++; if (pos != 8) $display("FAIL to_cycle got=%0d exp=8", pos); else passes++;
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (to_valid !== 1'b0) $display("FAIL to_valid_fall got=%b exp=0", to_valid); else passes++;
  endtask

  task automatic test_timeout_late_ack;
    int early;
    do_reset();
    req_valid = 2'b01;
    early = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (to_ack !== 2'b00) early++;
    end
    tick();
    ack_man   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    #1;
    checks++; if (early != 0) $display("FAIL late_early_ack got=%0d exp=0", early); else passes++;
    checks++; if (to_ack !== 2'b01) $display("FAIL late_ack got=%b exp=01", to_ack); else passes++;
    checks++; if (to_err !== 2'b00) $display("FAIL late_err got=%b exp=00", to_err); else passes++;
    checks++; if (to_rdata !== 32'hCAFEF00D) $display("FAIL late_data got=%h exp=cafef00d", to_rdata); else passes++;
    tick();
    ack_man   = 1'b0;
    req_valid = 2'b00;
    #1;
    checks++; if (to_valid !== 1'b0) $display("FAIL late_valid_fall got=%b exp=0", to_valid); else passes++;
  endtask

  task automatic test_reset_abort;
    do_reset();
    req_valid = 2'b10;
    tick();
    checks++; if (rr_addr !== 32'h100) $display("FAIL abort_addr got=%h exp=100", rr_addr); else passes++;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (rr_ack !== 2'b00) $display("FAIL abort_ack_in_rst got=%b exp=00", rr_ack); else passes++;
    tick();
    rst       = 1'b0;
    ack_man   = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++; if (rr_valid !== 1'b0) $display("FAIL abort_valid got=%b exp=0", rr_valid); else passes++;
    checks++; if (rr_ack !== 2'b00) $display("FAIL abort_late_ack got=%b exp=00", rr_ack); else passes++;
    tick();
    ack_man = 1'b0;
    #1;
    checks++; if (rr_valid !== 1'b1) $display("FAIL abort_regrant got=%b exp=1", rr_valid); else passes++;
    checks++; if (rr_addr !== 32'h200) $display("FAIL abort_ch0_addr got=%h exp=200", rr_addr); else passes++;
    checks++; if (rr_wdata !== 32'h22222222) $display("FAIL abort_ch0_wdata got=%h exp=22222222", rr_wdata); else passes++;
    checks++; if (rr_we !== 1'b1) $display("FAIL abort_ch0_we got=%b exp=1", rr_we); else passes++;
    checks++; if (rr_sel !== 4'hF) $display("FAIL abort_ch0_sel got=%h exp=f", rr_sel); else passes++;
    ack_man = 1'b1;
    #1;
    checks++; if (rr_ack !== 2'b01) $display("FAIL abort_ch0_ack got=%b exp=01", rr_ack); else passes++;
    tick();
    ack_man   = 1'b0;
    req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1);
  end

  initial begin
    req_addr  = {32'h0000_0100, 32'h0000_0200};
    req_data  = {32'h1111_1111, 32'h2222_2222};
    req_sel   = {4'h3, 4'hF};
    req_we    = 2'b01;
    req_valid = 2'b00;
    mem_rdata = 32'h0;
    ack_man   = 1'b0;
    auto_ack  = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_fixed_priority();
    test_timeout();
    test_timeout_late_ack();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
